// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the miniRV instruction-fetch stage:
// NOP encoding, fetch state encoding and the default reset PC.
package if_fetch_stage_pkg;

   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_RUN   = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/if_inst_hold.sv
// Holds the last live ROM word across a stall.
// Selects live, held or NOP output from the fetch state.
module if_inst_hold
   import if_fetch_stage_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_irom_inst,
   input  logic        i_capture,
   input  logic [1:0]  i_state,
   output logic [31:0] o_inst,
   output logic        o_valid
);

   logic [31:0] r_hold_inst;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hold_inst <= 32'h0;
      end else if (i_capture) begin
         r_hold_inst <= i_irom_inst;
      end
   end

   always_comb begin
      o_inst  = NOP_INST;
      o_valid = 1'b0;
      unique case (i_state)
         ST_RUN: begin
            o_inst  = i_irom_inst;
            o_valid = 1'b1;
         end
         ST_HOLD: begin
            o_inst  = r_hold_inst;
            o_valid = 1'b1;
         end
         default: begin
            o_inst  = NOP_INST;
            o_valid = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/if_fetch_stage.sv
// miniRV fetch stage: PC generation, 1-cycle sync IROM interface,
// stall hold and EX redirect.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          ADDR_W   = 14
) (
   input  logic              cpu_clk,
   input  logic              cpu_rst_n,
   input  logic              stall,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic [ADDR_W-1:0] irom_addr,
   input  logic [31:0]       irom_inst,
   output logic [31:0]       pc_IF_out,
   output logic [31:0]       pc4_IF_out,
   output logic [31:0]       inst_IF_out,
   output logic              inst_valid_IF_out
);

   logic [31:0]  r_pc_q;
   logic [31:0]  r_resp_pc;
   fetch_state_t r_state;

   logic [31:0]  w_pc_d;
   logic [31:0]  w_resp_d;
   fetch_state_t w_state_d;
   logic         w_capture;
   logic [31:0]  w_redir_pc;

   assign w_redir_pc = redirect_pc & ~32'd3;

   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         r_pc_q    <= RESET_PC;
         r_resp_pc <= 32'h0;
         r_state   <= ST_EMPTY;
      end else begin
         r_pc_q    <= w_pc_d;
         r_resp_pc <= w_resp_d;
         r_state   <= w_state_d;
      end
   end

   // redirect outranks stall; the three arms are mutually exclusive
   always_comb begin
      w_pc_d    = r_pc_q;
      w_resp_d  = r_resp_pc;
      w_state_d = r_state;
      w_capture = 1'b0;
      unique case (1'b1)
         redirect: begin
            w_pc_d    = w_redir_pc;
            w_state_d = ST_EMPTY;
         end
         (!redirect && stall): begin
            if (r_state == ST_RUN) begin
               w_state_d = ST_HOLD;
               w_capture = 1'b1;
            end
         end
         default: begin
            w_resp_d  = r_pc_q;
            w_pc_d    = r_pc_q + 32'd4;
            w_state_d = ST_RUN;
         end
      endcase
   end

   assign irom_addr  = r_pc_q[ADDR_W+1:2];
   assign pc_IF_out  = r_resp_pc;
   assign pc4_IF_out = r_resp_pc + 32'd4;

   if_inst_hold u_hold (
      .i_clk       (cpu_clk),
      .i_rst_n     (cpu_rst_n),
      .i_irom_inst (irom_inst),
      .i_capture   (w_capture),
      .i_state     (r_state),
      .o_inst      (inst_IF_out),
      .o_valid     (inst_valid_IF_out)
   );

endmodule
